// File: rtl/alu8_nibble_seq_pkg.sv
// Shared definitions for the nibble-sequenced 8-bit ALU.
//   alu_op_e   : 3-bit op codes shared with the 4-bit alu and the decoder
//   state_e    : sequencer states IDLE / LO / HI
//   FLAG_*_BIT : bit positions of Z, N, H, C in the CPU F register
//   alu_ctrl_t : op + carry-in pair driven into the 4-bit alu for one pass
package alu8_nibble_seq_pkg;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    ADC = 3'd1,
    SUB = 3'd2,
    SBC = 3'd3,
    AND = 3'd4,
    XOR = 3'd5,
    OR  = 3'd6,
    CP  = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2
  } state_e;

  localparam int unsigned FLAG_Z_BIT = 7;
  localparam int unsigned FLAG_N_BIT = 6;
  localparam int unsigned FLAG_H_BIT = 5;
  localparam int unsigned FLAG_C_BIT = 4;

  typedef struct packed {
    alu_op_e op;
    logic    cin;
  } alu_ctrl_t;

  // Assemble the F register image from individual flags (low nibble reads 0).
  function automatic logic [7:0] pack_flags(input logic z, input logic n,
                                            input logic h, input logic c);
    logic [7:0] f;
    f             = '0;
    f[FLAG_Z_BIT] = z;
    f[FLAG_N_BIT] = n;
    f[FLAG_H_BIT] = h;
    f[FLAG_C_BIT] = c;
    return f;
  endfunction

endpackage

// File: rtl/alu8_nibble_seq_alu.sv
// Existing 4-bit ALU shared by the execute stage.
//   in_A, in_B : 4-bit operands
//   in_C       : carry (adc) or borrow (sbc) input
//   alu_op     : op code, alu_op_e encoding
//   out        : 4-bit result (cp returns in_A unchanged)
//   out_C      : carry out for add-type ops, borrow out for subtract-type ops,
//                0 for logic ops
module alu
  import alu8_nibble_seq_pkg::*;
(
  input  logic [3:0] in_A,
  input  logic [3:0] in_B,
  input  logic       in_C,
  input  logic [2:0] alu_op,
  output logic [3:0] out,
  output logic       out_C
);

  logic [4:0] wide;

  // Bit 4 of the 5-bit sum/difference is the carry or borrow.
  always_comb begin
    wide = '0;
    case (alu_op_e'(alu_op))
      ADD:     wide = {1'b0, in_A} + {1'b0, in_B};
      ADC:     wide = {1'b0, in_A} + {1'b0, in_B} + {4'b0, in_C};
      SUB, CP: wide = {1'b0, in_A} - {1'b0, in_B};
      SBC:     wide = {1'b0, in_A} - {1'b0, in_B} - {4'b0, in_C};
      AND:     wide = {1'b0, in_A & in_B};
      XOR:     wide = {1'b0, in_A ^ in_B};
      OR:      wide = {1'b0, in_A | in_B};
      default: wide = '0;
    endcase
    out   = (alu_op_e'(alu_op) == CP) ? in_A : wide[3:0];
    out_C = wide[4];
  end

endmodule

// File: rtl/alu8_nibble_seq.sv
// Executes one 8-bit arithmetic/logic instruction by running the shared 4-bit
// alu twice: low nibble (LO) then high nibble (HI). Result and Z/N/H/C flags
// are registered at the end of HI, with a one-cycle done pulse afterwards.
//   clk, rst_n      : clock, asynchronous active-low reset
//   start, ready    : request / idle handshake (start sampled only when ready)
//   op, a, b        : op code (alu_op_e) and 8-bit operands
//   carry_in        : current C flag, consumed by adc/sbc
//   done            : one-cycle pulse when result/flags update
//   result, flag_*  : registered 8-bit result and Z/N/H/C flags
module alu8_nibble_seq
  import alu8_nibble_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       carry_in,
  output logic       ready,
  output logic       done,
  output logic [7:0] result,
  output logic       flag_z,
  output logic       flag_n,
  output logic       flag_h,
  output logic       flag_c
);

  state_e     state_q;
  alu_op_e    op_q;
  logic [7:0] a_q;
  logic [7:0] b_q;
  logic       cin_q;
  logic [3:0] lo_res_q;
  logic       lo_c_q;
  logic       ready_q;
  logic       done_q;
  logic [7:0] result_q;
  logic       z_q, n_q, h_q, c_q;

  logic [7:0] result_d;
  logic       z_d, n_d, h_d, c_d;
  logic [7:0] wide_res;

  logic [3:0] alu_a;
  logic [3:0] alu_b;
  alu_ctrl_t  ctrl;
  logic [3:0] alu_out;
  logic       alu_c;

  // Per-pass alu control. Subtract-type ops (including cp) run sub/sbc so the
  // alu's own cp op is never issued; the high pass chains the low pass carry.
  function automatic alu_ctrl_t pass_ctrl(input alu_op_e o, input logic hi_pass,
                                          input logic user_c, input logic lo_c);
    alu_ctrl_t r;
    case (o)
      ADD:     r = hi_pass ? '{op: ADC, cin: lo_c} : '{op: ADD, cin: 1'b0};
      ADC:     r = hi_pass ? '{op: ADC, cin: lo_c} : '{op: ADC, cin: user_c};
      SUB, CP: r = hi_pass ? '{op: SBC, cin: lo_c} : '{op: SUB, cin: 1'b0};
      SBC:     r = hi_pass ? '{op: SBC, cin: lo_c} : '{op: SBC, cin: user_c};
      default: r = '{op: o, cin: 1'b0};
    endcase
    return r;
  endfunction

  always_comb begin
    alu_a = '0;
    alu_b = '0;
    ctrl  = '{op: ADD, cin: 1'b0};
    case (state_q)
      LO: begin
        alu_a = a_q[3:0];
        alu_b = b_q[3:0];
        ctrl  = pass_ctrl(op_q, 1'b0, cin_q, lo_c_q);
      end
      HI: begin
        alu_a = a_q[7:4];
        alu_b = b_q[7:4];
        ctrl  = pass_ctrl(op_q, 1'b1, cin_q, lo_c_q);
      end
      default: ;
    endcase
  end

  alu u_alu (
    .in_A   (alu_a),
    .in_B   (alu_b),
    .in_C   (ctrl.cin),
    .alu_op (ctrl.op),
    .out    (alu_out),
    .out_C  (alu_c)
  );

  // Values written at the end of HI. Z always covers the full 8-bit ALU
  // result; for cp that is a-b, while the visible result stays a.
  always_comb begin
    wide_res = {alu_out, lo_res_q};
    result_d = wide_res;
    z_d      = (wide_res == '0);
    n_d      = 1'b0;
    h_d      = lo_c_q;
    c_d      = alu_c;
    case (op_q)
      SUB, SBC: n_d = 1'b1;
      CP: begin
        result_d = a_q;
        n_d      = 1'b1;
      end
      AND: begin
        h_d = 1'b1;
        c_d = 1'b0;
      end
      XOR, OR: begin
        h_d = 1'b0;
        c_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= ADD;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      lo_res_q <= '0;
      lo_c_q   <= 1'b0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      result_q <= '0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      h_q      <= 1'b0;
      c_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && ready_q) begin
            state_q <= LO;
            ready_q <= 1'b0;
            op_q    <= alu_op_e'(op);
            a_q     <= a;
            b_q     <= b;
            cin_q   <= carry_in;
          end
        end
        LO: begin
          lo_res_q <= alu_out;
          lo_c_q   <= alu_c;
          state_q  <= HI;
        end
        HI: begin
          state_q  <= IDLE;
          ready_q  <= 1'b1;
          done_q   <= 1'b1;
          result_q <= result_d;
          z_q      <= z_d;
          n_q      <= n_d;
          h_q      <= h_d;
          c_q      <= c_d;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready  = ready_q;
  assign done   = done_q;
  assign result = result_q;
  assign flag_z = z_q;
  assign flag_n = n_q;
  assign flag_h = h_q;
  assign flag_c = c_q;

endmodule

// File: tb/tb_alu8_nibble_seq.sv
// Self-checking bench for alu8_nibble_seq: directed vector table, randomized
// ops against a plain-arithmetic reference model, a held-start burst and a
// reset during the high-nibble pass.
module tb_alu8_nibble_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [2:0] op;
  logic [7:0] a, b;
  logic       carry_in;
  logic       ready, done;
  logic [7:0] result;
  logic       flag_z, flag_n, flag_h, flag_c;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu8_nibble_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .carry_in (carry_in),
    .ready    (ready),
    .done     (done),
    .result   (result),
    .flag_z   (flag_z),
    .flag_n   (flag_n),
    .flag_h   (flag_h),
    .flag_c   (flag_c)
  );

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] res;
    logic [3:0] znhc;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference: whole-byte arithmetic, H from the low nibbles alone.
  function automatic logic [11:0] model(input logic [2:0] o, input logic [7:0] x,
                                        input logic [7:0] y, input logic ci_in);
    int ci, full, lo;
    logic [7:0] r;
    logic z, n, h, c;
    ci = (o == 3'd1 || o == 3'd3) ? int'(ci_in) : 0;
    r = '0; n = 1'b0; h = 1'b0; c = 1'b0;
    full = 0; lo = 0;
    case (o)
      3'd0, 3'd1: begin
        full = int'(x) + int'(y) + ci;
        lo   = int'(x[3:0]) + int'(y[3:0]) + ci;
        r = 8'(full); h = (lo > 15); c = (full > 255);
      end
      3'd2, 3'd3, 3'd7: begin
        full = int'(x) - int'(y) - ci;
        lo   = int'(x[3:0]) - int'(y[3:0]) - ci;
        r = 8'(full); h = (lo < 0); c = (full < 0); n = 1'b1;
      end
      3'd4: begin r = x & y; h = 1'b1; end
      3'd5: r = x ^ y;
      default: r = x | y;
    endcase
    z = (r == 8'h00);
    if (o == 3'd7) r = x;
    return {r, z, n, h, c};
  endfunction

  function automatic logic [11:0] dut_out();
    return {result, flag_z, flag_n, flag_h, flag_c};
  endfunction

  // Starts at a negedge with ready high; returns at the negedge in which done
  // is seen (edges = rising edges from acceptance, 10 on timeout).
  task automatic do_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                       input logic ci, output int edges, output logic busy_rdy);
    op = o; a = x; b = y; carry_in = ci; start = 1'b1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    busy_rdy = ready;
    start = 1'b0;
    op = 3'($urandom); a = 8'($urandom); b = 8'($urandom); carry_in = 1'($urandom);
    while (!done && edges < 10) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
  endtask

  initial begin
    int edges;
    logic busy;
    logic [2:0] sop[6];
    logic [7:0] sa[6], sb[6];
    logic sc[6];
    int pulses, idx, cnt;

    vecs[0]  = '{3'd0, 8'h3A, 8'hC6, 1'b0, 8'h00, 4'b1011};
    vecs[1]  = '{3'd1, 8'hE1, 8'h0F, 1'b1, 8'hF1, 4'b0010};
    vecs[2]  = '{3'd1, 8'hE1, 8'h0F, 1'b0, 8'hF0, 4'b0010};
    vecs[3]  = '{3'd2, 8'h3E, 8'h0F, 1'b1, 8'h2F, 4'b0110};
    vecs[4]  = '{3'd3, 8'h3B, 8'h4F, 1'b1, 8'hEB, 4'b0111};
    vecs[5]  = '{3'd7, 8'h3C, 8'h3C, 1'b0, 8'h3C, 4'b1100};
    vecs[6]  = '{3'd7, 8'h10, 8'h20, 1'b0, 8'h10, 4'b0101};
    vecs[7]  = '{3'd4, 8'h5A, 8'h3F, 1'b1, 8'h1A, 4'b0010};
    vecs[8]  = '{3'd5, 8'hFF, 8'hFF, 1'b0, 8'h00, 4'b1000};
    vecs[9]  = '{3'd6, 8'hA0, 8'h03, 1'b0, 8'hA3, 4'b0000};
    vecs[10] = '{3'd0, 8'h3A, 8'hC5, 1'b1, 8'hFF, 4'b0000};

    rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; carry_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ready", ready, 1);
    chk("reset_done", done, 0);
    chk("reset_out", dut_out(), 12'h000);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table, issued back-to-back (each start lands in the done cycle).
    for (int i = 0; i < 11; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, edges, busy);
      chk($sformatf("vec%0d_latency", i), edges, 3);
      chk($sformatf("vec%0d_busy_ready", i), busy, 0);
      chk($sformatf("vec%0d_out", i), dut_out(), {vecs[i].res, vecs[i].znhc});
      chk($sformatf("vec%0d_ready", i), ready, 1);
    end

    // Randomized ops with optional idle gaps.
    for (int i = 0; i < 200; i++) begin
      logic [2:0] ro; logic [7:0] ra, rb; logic rc;
      ro = 3'($urandom); ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_op(ro, ra, rb, rc, edges, busy);
      chk($sformatf("rand%0d_latency", i), edges, 3);
      chk($sformatf("rand%0d_out op=%0d a=%0h b=%0h c=%0d", i, ro, ra, rb, rc),
          dut_out(), model(ro, ra, rb, rc));
    end

    // start held for six cycles: only cycles 0 and 3 are accepted.
    repeat (2) @(negedge clk);
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      if (done) begin
        pulses++;
        idx = (pulses == 1) ? 0 : 3;
        chk("burst_done_cycle", k, (pulses == 1) ? 3 : 6);
        chk("burst_out", dut_out(), model(sop[idx], sa[idx], sb[idx], sc[idx]));
      end
      if (k == 3) chk("burst_ready_in_done_cycle", ready, 1);
      if (k < 6) begin
        sop[k] = 3'($urandom); sa[k] = 8'($urandom); sb[k] = 8'($urandom); sc[k] = 1'($urandom);
        op = sop[k]; a = sa[k]; b = sb[k]; carry_in = sc[k]; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    chk("burst_pulses", pulses, 2);

    // Reset asserted during HI.
    do_op(3'd6, 8'hA0, 8'h03, 1'b0, edges, busy);
    chk("pre_reset_out", dut_out(), 12'hA30);
    op = 3'd0; a = 8'hFF; b = 8'h01; carry_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_hi_ready", ready, 1);
    chk("rst_hi_done", done, 0);
    chk("rst_hi_out", dut_out(), 12'h000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      if (done) cnt++;
      @(negedge clk);
    end
    chk("rst_hi_no_done", cnt, 0);
    chk("rst_hi_ready_after", ready, 1);
    do_op(vecs[4].op, vecs[4].a, vecs[4].b, vecs[4].cin, edges, busy);
    chk("post_reset_latency", edges, 3);
    chk("post_reset_out", dut_out(), {vecs[4].res, vecs[4].znhc});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu8_nibble_seq.md
Name: alu8_nibble_seq

Overview:
- Sequences the existing 4-bit `alu` over two clock passes, low nibble then high nibble, to execute one 8-bit CPU arithmetic/logic instruction.
- Returns an 8-bit result plus Game Boy-style flags Z, N, H, C.
- Sits between the instruction decoder/execute stage and the single shared 4-bit ALU, and owns that ALU's inputs for the whole operation.
- Uses a start/ready/done handshake; one operation completes every 3 cycles.

Parameters:
- None. Widths are fixed: 8-bit operands, 4-bit ALU, 3-bit op code.

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only while ready=1
- op  in  3  0 add, 1 adc, 2 sub, 3 sbc, 4 and, 5 xor, 6 or, 7 cp (same encoding as alu_op)
- a  in  8  accumulator operand; captured on an accepted start
- b  in  8  second operand; captured on an accepted start
- carry_in  in  1  current C flag, used by adc/sbc; captured on an accepted start
- ready  out  1  high when idle and able to accept start
- done  out  1  one-cycle pulse when result/flags are updated
- result  out  8  registered 8-bit result
- flag_z  out  1  registered zero flag
- flag_n  out  1  registered subtract flag
- flag_h  out  1  registered half-carry/half-borrow flag (nibble boundary)
- flag_c  out  1  registered carry/borrow flag

Behaviour:
- Clock and reset (already decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values:
  - state=IDLE, ready=1, done=0, result=0x00, all flags 0.
  - Operand and low-nibble registers = 0.
- FSM states:
  - IDLE → LO on start&ready; latch op, a, b, carry_in.
  - LO → HI unconditionally.
  - HI → IDLE unconditionally; result and flags are written on this edge; done=1 in the following (IDLE) cycle.
- Latency and throughput:
  - start accepted at edge N → done high and outputs valid during cycle N+3.
  - A start in the done cycle is accepted, giving back-to-back operations with 3-cycle throughput.
  - start while ready=0 is ignored (not queued); the latched operands are unaffected.
- LO pass: drive alu in_A=a[3:0], in_B=b[3:0], and the low alu_op/in_C per op:
  - add: add, in_C=0
  - adc: adc, in_C=carry_in
  - sub, cp: sub, in_C=0
  - sbc: sbc, in_C=carry_in
  - logic ops: same op, in_C=0
  - Register lo_res=out and lo_c=out_C.
- HI pass: drive in_A=a[7:4], in_B=b[7:4], and the high alu_op/in_C per op:
  - add/adc: adc, in_C=lo_c
  - sub/sbc/cp: sbc, in_C=lo_c
  - logic ops: same op, in_C=0
- The ALU cp op is never issued; cp is computed as a subtraction.
- alu out_C means carry for add-type ops and borrow for subtract-type ops.
- Result and flags written at end of HI:
  - Arithmetic (add/adc/sub/sbc): result={hi_out,lo_res}; Z=(result==0); N=1 for sub/sbc, else 0; H=lo_c; C=hi out_C.
  - cp: result=a (accumulator unchanged); Z=(a-b==0); N=1; H and C taken from the subtraction.
  - and: H=1, N=0, C=0.
  - xor/or: H=0, N=0, C=0.
  - Z is always computed over all 8 result bits, never per nibble.
- Outputs hold their last values until the next HI-end write. ALU input drive in IDLE is don't-care and held at 0 for lint.
- Reset mid-operation: the operation is abandoned with no done pulse; on rst_n release the block is in IDLE with ready=1.
- done never asserts without a preceding accepted start.

Decomposition:
- Shared package/header holds:
  - op code constants ADD..CP (shared with alu and the decoder)
  - FSM state encodings IDLE/LO/HI
  - flag bit positions Z=7, N=6, H=5, C=4 for the F register
- One sub-module: the existing `alu`, instantiated once inside alu8_nibble_seq.
- The op-to-(alu_op, in_C) mapping stays a local combinational function, not a separate module.

Test Plan:
- add a=0x3A b=0xC6 → result 0x00, Z=1 N=0 H=1 C=1; done exactly 3 cycles after the start edge.
- adc a=0xE1 b=0x0F carry_in=1 → result 0xF1, Z=0 N=0 H=1 C=0; same operands with carry_in=0 → 0xF0, H=1, C=0.
- sub a=0x3E b=0x0F → 0x2F, Z=0 N=1 H=1 C=0; sbc a=0x3B b=0x4F carry_in=1 → 0xEB, N=1 H=1 C=1.
- cp a=0x3C b=0x3C → result 0x3C, Z=1 N=1 H=0 C=0; cp a=0x10 b=0x20 → result 0x10, Z=0 C=1 H=0.
- Logic ops: and 0x5A,0x3F → 0x1A, H=1 C=0 N=0; xor 0xFF,0xFF → 0x00, Z=1 H=0; or 0xA0,0x03 → 0xA3, Z=0.
- Handshake and reset:
  - start held high for 6 cycles → exactly two done pulses, operands taken from the two accepted starts only.
  - rst_n low during HI → no done pulse, result=0x00, flags 0, ready=1 immediately (asynchronous).
